mac_accum_8_bit: RTL and testbench

//  Multiply-accumulate back end for the 8-bit ALU. Sits directly downstream of the

---
 rtl/mac_accum_8_bit.sv | 123 ++++++++++++
 tb/tb_mac_accum_8_bit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accum_8_bit.sv
// Sums a run of len signed 16-bit products into an ACC_W-bit total; the result is valid the cycle after the last accept.
// in_ready is held low while a result waits for out_ready. Define MAC_SAT_EN to saturate instead of wrap on overflow.
module mac_accum_8_bit #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      p_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       len,
    input  logic             clear,
    output logic [ACC_W-1:0] acc_out,
    output logic [7:0]       cnt_out,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       len_q, len_d;
    logic             ovf_q, ovf_d;
    logic             live_q;

    logic [ACC_W-1:0] p_ext;
    logic [ACC_W-1:0] sum_wrap;
    logic [ACC_W-1:0] sum_next;
    logic             add_ovf;
    logic             accept;

    assign p_ext    = {{(ACC_W-16){p_in[15]}}, p_in};
    assign sum_wrap = acc_q + p_ext;
    // Overflow: both operands share a sign that the wrapped sum does not.
    assign add_ovf  = (acc_q[ACC_W-1] == p_ext[ACC_W-1]) && (sum_wrap[ACC_W-1] != acc_q[ACC_W-1]);

`ifdef MAC_SAT_EN
    always_comb begin
        sum_next = sum_wrap;
        if (add_ovf) begin
            sum_next = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign sum_next = sum_wrap;
`endif

    // live_q keeps in_ready low until the first clock after reset release.
    assign in_ready  = live_q && (state_q != DONE) && !clear;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign acc_out   = acc_q;
    assign cnt_out   = cnt_q;
    assign ovf       = ovf_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_d   = p_ext;
                        cnt_d   = 8'd1;
                        ovf_d   = 1'b0;
                        len_d   = (len == 8'd0) ? 8'd1 : len;
                        state_d = (len <= 8'd1) ? DONE : ACC;
                    end
                end
                ACC: begin
                    if (accept) begin
                        acc_d = sum_next;
                        cnt_d = cnt_q + 8'd1;
                        ovf_d = ovf_q | add_ovf;
                        if (cnt_q + 8'd1 == len_q) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= 8'd1;
            ovf_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            live_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mac_accum_8_bit.sv
module tb_mac_accum_8_bit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] p_in;
    logic        in_valid, in_ready;
    logic [7:0]  len;
    logic        clear;
    logic [23:0] acc_out;
    logic [7:0]  cnt_out;
    logic        ovf, out_valid, out_ready;

    logic [15:0] p_s;
    logic        v_s, rdy_s;
    logic [7:0]  len_s;
    logic        clr_s;
    logic [16:0] acc_s;
    logic [7:0]  cnt_s;
    logic        ovf_s, ov_s, ordy_s;

    mac_accum_8_bit #(.ACC_W(24)) u_dut (
        .clk(clk), .rst(rst), .p_in(p_in), .in_valid(in_valid), .in_ready(in_ready),
        .len(len), .clear(clear), .acc_out(acc_out), .cnt_out(cnt_out), .ovf(ovf),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    mac_accum_8_bit #(.ACC_W(17)) u_dut17 (
        .clk(clk), .rst(rst), .p_in(p_s), .in_valid(v_s), .in_ready(rdy_s),
        .len(len_s), .clear(clr_s), .acc_out(acc_s), .cnt_out(cnt_s), .ovf(ovf_s),
        .out_valid(ov_s), .out_ready(ordy_s)
    );

    typedef struct packed {
        logic [23:0] acc;
        logic [7:0]  cnt;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic pop_exp(output exp_t e);
        if (sb.size() == 0) e = 'x;
        else e = sb.pop_front();
    endtask

    // Offers one product from a negedge; returns at the negedge after it is accepted.
    task automatic send(input logic [15:0] p, input logic [7:0] l);
        int n;
        p_in = p; len = l; in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; p_in = '0; in_valid = 1'b0; len = '0; clear = 1'b0; out_ready = 1'b1;
        p_s = '0; v_s = 1'b0; len_s = '0; clr_s = 1'b0; ordy_s = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({acc_out, cnt_out, ovf, out_valid, in_ready} !== {24'h0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_outputs: acc=%h cnt=%0d ovf=%b ov=%b rdy=%b required all 0",
                     acc_out, cnt_out, ovf, out_valid, in_ready);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_rdy: in_ready=%b required 0 before first clk", in_ready);
        end
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_first_clk_rdy: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_basic;
        exp_t e;
        send(16'h0010, 8'd3);
        send(16'hFFF0, 8'd3);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL t1_early_valid: out_valid=%b required 0", out_valid);
        end
        send(16'h0005, 8'd3);
        in_valid = 1'b0;
        sb.push_back('{acc: 24'h000005, cnt: 8'd3, ovf: 1'b0});
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL t1_latency: out_valid=%b required 1", out_valid);
        end
        pop_exp(e);
        tests++;
        if ({acc_out, cnt_out, ovf} !== e) begin
            fails++;
            $display("FAIL t1_result: got %h/%0d/%b required %h/%0d/%b", acc_out, cnt_out, ovf, e.acc, e.cnt, e.ovf);
        end
        @(negedge clk);
        tests++;
        if ({out_valid, acc_out, cnt_out} !== {1'b0, 24'h000005, 8'd3}) begin
            fails++;
            $display("FAIL t1_handoff: ov=%b acc=%h cnt=%0d required 0/000005/3", out_valid, acc_out, cnt_out);
        end
    endtask

    task automatic test_backpressure;
        exp_t e;
        bit ok;
        out_ready = 1'b0;
        send(16'h0010, 8'd3);
        send(16'hFFF0, 8'd3);
        send(16'h0005, 8'd3);
        sb.push_back('{acc: 24'h000005, cnt: 8'd3, ovf: 1'b0});
        p_in = 16'h0001; len = 8'd1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++;
            if ({in_ready, out_valid, acc_out, cnt_out} !== {1'b0, 1'b1, 24'h000005, 8'd3}) begin
                fails++;
                $display("FAIL t3_stall_%0d: rdy=%b ov=%b acc=%h cnt=%0d required 0/1/000005/3",
                         i, in_ready, out_valid, acc_out, cnt_out);
            end
            @(negedge clk);
        end
        pop_exp(e);
        tests++;
        if ({acc_out, cnt_out, ovf} !== e) begin
            fails++;
            $display("FAIL t3_result: got %h/%0d/%b required %h/%0d/%b", acc_out, cnt_out, ovf, e.acc, e.cnt, e.ovf);
        end
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        tests++;
        if ({out_valid, acc_out, cnt_out, in_ready} !== {1'b0, 24'h000005, 8'd3, 1'b1}) begin
            fails++;
            $display("FAIL t3_handoff: ov=%b acc=%h cnt=%0d rdy=%b required 0/000005/3/1",
                     out_valid, acc_out, cnt_out, in_ready);
        end
        sb.push_back('{acc: 24'h000001, cnt: 8'd1, ovf: 1'b0});
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(ok);
        pop_exp(e);
        tests++;
        if (!ok || {acc_out, cnt_out, ovf} !== e) begin
            fails++;
            $display("FAIL t3_next_run: ov=%b got %h/%0d/%b required %h/%0d/%b",
                     out_valid, acc_out, cnt_out, ovf, e.acc, e.cnt, e.ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_clear;
        exp_t e;
        bit ok;
        send(16'h0010, 8'd4);
        p_in = 16'h0020; in_valid = 1'b1; clear = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL t4_clear_rdy: in_ready=%b required 0", in_ready);
        end
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        #1;
        tests++;
        if ({acc_out, cnt_out, ovf, out_valid, in_ready} !== {24'h0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL t4_cleared: acc=%h cnt=%0d ovf=%b ov=%b rdy=%b required 0/0/0/0/1",
                     acc_out, cnt_out, ovf, out_valid, in_ready);
        end
        @(negedge clk);
        send(16'hFF80, 8'd1);
        in_valid = 1'b0;
        sb.push_back('{acc: 24'hFFFF80, cnt: 8'd1, ovf: 1'b0});
        wait_out(ok);
        pop_exp(e);
        tests++;
        if (!ok || {acc_out, cnt_out, ovf} !== e) begin
            fails++;
            $display("FAIL t4_after_clear: ov=%b got %h/%0d/%b required %h/%0d/%b",
                     out_valid, acc_out, cnt_out, ovf, e.acc, e.cnt, e.ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_len0;
        exp_t e;
        send(16'h1234, 8'd0);
        in_valid = 1'b0;
        sb.push_back('{acc: 24'h001234, cnt: 8'd1, ovf: 1'b0});
        pop_exp(e);
        tests++;
        if ({out_valid, acc_out, cnt_out, ovf} !== {1'b1, e}) begin
            fails++;
            $display("FAIL t5_len0: ov=%b got %h/%0d/%b required 1 %h/%0d/%b",
                     out_valid, acc_out, cnt_out, ovf, e.acc, e.cnt, e.ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_overflow;
        exp_t e;
        logic [15:0] prod [2];
        logic [16:0] want [2];
        prod[0] = 16'h7FFF;
        prod[1] = 16'h8000;
`ifdef MAC_SAT_EN
        want[0] = 17'h0FFFF;
        want[1] = 17'h10000;
`else
        want[0] = 17'h17FFD;
        want[1] = 17'h08000;
`endif
        for (int c = 0; c < 2; c++) begin
            sb.push_back('{acc: {7'h0, want[c]}, cnt: 8'd3, ovf: 1'b1});
            for (int k = 0; k < 3; k++) begin
                p_s = prod[c]; len_s = 8'd3; v_s = 1'b1;
                @(posedge clk);
                @(negedge clk);
            end
            v_s = 1'b0;
            pop_exp(e);
            tests++;
            if ({ov_s, 7'h0, acc_s, cnt_s, ovf_s} !== {1'b1, e}) begin
                fails++;
                $display("FAIL t2_overflow_%0d: ov=%b got %h/%0d/%b required 1 %h/%0d/%b",
                         c, ov_s, acc_s, cnt_s, ovf_s, e.acc, e.cnt, e.ovf);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset;
        exp_t e;
        bit ok;
        send(16'h0007, 8'd4);
        send(16'h0009, 8'd4);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({acc_out, cnt_out, ovf, out_valid, in_ready} !== {24'h0, 8'd0, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL t6_async_rst: acc=%h cnt=%0d ovf=%b ov=%b rdy=%b required all 0",
                     acc_out, cnt_out, ovf, out_valid, in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        send(16'h0002, 8'd2);
        send(16'h0003, 8'd2);
        in_valid = 1'b0;
        sb.push_back('{acc: 24'h000005, cnt: 8'd2, ovf: 1'b0});
        wait_out(ok);
        pop_exp(e);
        tests++;
        if (!ok || {acc_out, cnt_out, ovf} !== e) begin
            fails++;
            $display("FAIL t6_after_rst: ov=%b got %h/%0d/%b required %h/%0d/%b",
                     out_valid, acc_out, cnt_out, ovf, e.acc, e.cnt, e.ovf);
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_clear();
        test_len0();
        test_overflow();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
